// File: rtl/burst_if_pkg.sv
// Shared types and timing constants for the simple burst
// memory interface responder.
package burst_if_pkg;

  localparam int BURST_LEN_BITS = 10;

  // Finish pulse offset after the last data_req / read issue.
  localparam int WR_FIN_OFS = 1;
  localparam int RD_FIN_OFS = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRITE_FIN,
    S_READ,
    S_READ_LAST,
    S_READ_FIN
  } state_t;

endpackage

// File: rtl/simple_dp_ram.sv
// Simple dual-port RAM: one write port, one synchronous
// read port with 1-cycle latency, no reset.
module simple_dp_ram #(
  parameter int DATA_BITS  = 64,
  parameter int DEPTH_BITS = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_BITS-1:0] i_waddr,
  input  logic [DATA_BITS-1:0]  i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_BITS-1:0] i_raddr,
  output logic [DATA_BITS-1:0]  o_rdata
);

  logic [DATA_BITS-1:0] r_mem [2**DEPTH_BITS];
  logic [DATA_BITS-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/burst_bram_responder.sv
// Burst memory responder backed by on-chip RAM; stands in
// for DDR during PL-only bring-up and initiator simulation.
module burst_bram_responder
  import burst_if_pkg::*;
#(
  parameter int MEM_DATA_BITS  = 64,
  parameter int ADDR_BITS      = 32,
  parameter int MEM_DEPTH_BITS = 10
) (
  input  logic                      mem_clk,
  input  logic                      rst,
  input  logic                      wr_burst_req,
  input  logic [BURST_LEN_BITS-1:0] wr_burst_len,
  input  logic [ADDR_BITS-1:0]      wr_burst_addr,
  output logic                      wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0]  wr_burst_data,
  output logic                      wr_burst_finish,
  input  logic                      rd_burst_req,
  input  logic [BURST_LEN_BITS-1:0] rd_burst_len,
  input  logic [ADDR_BITS-1:0]      rd_burst_addr,
  output logic                      rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0]  rd_burst_data,
  output logic                      rd_burst_finish,
  output logic                      busy
);

  state_t r_state;
  state_t w_next;

  logic [BURST_LEN_BITS-1:0] r_cnt;
  logic [BURST_LEN_BITS-1:0] r_len;
  logic [BURST_LEN_BITS-1:0] w_last_cnt;
  logic [ADDR_BITS-1:0]      r_addr;
  logic [MEM_DEPTH_BITS-1:0] w_idx;
  logic [MEM_DEPTH_BITS-1:0] r_wr_idx;
  logic [MEM_DATA_BITS-1:0]  w_ram_q;

  logic w_wr_acc;
  logic w_rd_acc;
  logic w_wr_dreq;
  logic w_rd_issue;
  logic w_wr_fin;
  logic w_rd_fin;
  logic r_wr_pend;
  logic r_rd_valid;
  logic r_rd_hold;

  // Bursts wrap modulo the RAM depth; upper address bits drop out.
  assign w_idx = MEM_DEPTH_BITS'(r_addr + ADDR_BITS'(r_cnt));
  assign w_last_cnt = r_len - BURST_LEN_BITS'(1);

  assign w_wr_acc = (r_state == S_IDLE) && wr_burst_req;
  assign w_rd_acc = (r_state == S_IDLE) && !wr_burst_req
                    && rd_burst_req;

  always_comb begin
    w_next     = r_state;
    w_wr_dreq  = 1'b0;
    w_rd_issue = 1'b0;
    w_wr_fin   = 1'b0;
    w_rd_fin   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (wr_burst_req) begin
          w_next = (wr_burst_len == '0) ? S_WRITE_FIN : S_WRITE;
        end else if (rd_burst_req) begin
          w_next = (rd_burst_len == '0) ? S_READ_FIN : S_READ;
        end
      end
      S_WRITE: begin
        w_wr_dreq = 1'b1;
        if (r_cnt == w_last_cnt) w_next = S_WRITE_FIN;
      end
      S_WRITE_FIN: begin
        w_wr_fin = 1'b1;
        w_next   = S_IDLE;
      end
      S_READ: begin
        w_rd_issue = 1'b1;
        if (r_cnt == w_last_cnt) w_next = S_READ_LAST;
      end
      S_READ_LAST: w_next = S_READ_FIN;
      S_READ_FIN: begin
        w_rd_fin = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_len  <= '0;
      r_addr <= '0;
    end else if (w_wr_acc) begin
      r_cnt  <= '0;
      r_len  <= wr_burst_len;
      r_addr <= wr_burst_addr;
    end else if (w_rd_acc) begin
      r_cnt  <= '0;
      r_len  <= rd_burst_len;
      r_addr <= rd_burst_addr;
    end else if (w_wr_dreq || w_rd_issue) begin
      r_cnt <= r_cnt + BURST_LEN_BITS'(1);
    end
  end

  // Write data trails data_req by one cycle, so the index rides along.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_wr_pend  <= 1'b0;
      r_wr_idx   <= '0;
      r_rd_valid <= 1'b0;
      r_rd_hold  <= 1'b0;
    end else begin
      r_wr_pend  <= w_wr_dreq;
      r_wr_idx   <= w_idx;
      r_rd_valid <= w_rd_issue;
      r_rd_hold  <= r_rd_hold | w_rd_issue;
    end
  end

  simple_dp_ram #(
    .DATA_BITS  (MEM_DATA_BITS),
    .DEPTH_BITS (MEM_DEPTH_BITS)
  ) u_ram (
    .i_clk   (mem_clk),
    .i_we    (r_wr_pend),
    .i_waddr (r_wr_idx),
    .i_wdata (wr_burst_data),
    .i_re    (w_rd_issue),
    .i_raddr (w_idx),
    .o_rdata (w_ram_q)
  );

  // RAM output has no reset; read data shows zero until a read lands.
  assign rd_burst_data       = r_rd_hold ? w_ram_q : '0;
  assign rd_burst_data_valid = r_rd_valid;
  assign wr_burst_data_req   = w_wr_dreq;
  assign wr_burst_finish     = w_wr_fin;
  assign rd_burst_finish     = w_rd_fin;
  assign busy                = (r_state != S_IDLE);

endmodule

// File: tb/tb_burst_bram_responder.sv
// Randomized bench for burst_bram_responder against a
// cycle-numbered burst model and a shadow memory array.
module tb_burst_bram_responder;
  import burst_if_pkg::*;

  localparam int DEPTH = 1024;

  logic        mem_clk = 1'b0;
  logic        rst;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [31:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic [63:0] wr_burst_data;
  logic        wr_burst_finish;
  logic        rd_burst_req;
  logic [9:0]  rd_burst_len;
  logic [31:0] rd_burst_addr;
  logic        rd_burst_data_valid;
  logic [63:0] rd_burst_data;
  logic        rd_burst_finish;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [63:0] mdl [DEPTH];
  bit          known [DEPTH];

  always #5 mem_clk = ~mem_clk;

  burst_bram_responder dut (
    .mem_clk             (mem_clk),
    .rst                 (rst),
    .wr_burst_req        (wr_burst_req),
    .wr_burst_len        (wr_burst_len),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_data       (wr_burst_data),
    .wr_burst_finish     (wr_burst_finish),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_finish     (rd_burst_finish),
    .busy                (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] beat_val(input int mode, input int k);
    logic [7:0] b;
    case (mode)
      1:       b = 8'(k);
      2:       b = 8'(k + 1);
      default: return rnd64();
    endcase
    return {8{b}};
  endfunction

  function automatic int idx_of(input logic [31:0] a, input int k);
    logic [31:0] s;
    s = a + 32'(k);
    return int'(s % DEPTH);
  endfunction

  task automatic nxt();
    @(posedge mem_clk);
    @(negedge mem_clk);
  endtask

  // Returns once the current cycle is the accept cycle (cycle 0).
  task automatic wait_accept(input string tag, input int exp_wait);
    int w = 0;
    while (busy && w < 4) begin
      nxt();
      w++;
    end
    chk(tag, 64'(w), 64'(exp_wait));
  endtask

  task automatic do_wr(input logic [31:0] a, input int n,
                       input int mode, input int exp_wait);
    int  k = 0;
    bit  prev = 0;
    int  fin = n + WR_FIN_OFS;
    logic [63:0] b;
    wr_burst_req  = 1'b1;
    wr_burst_len  = 10'(n);
    wr_burst_addr = a;
    wait_accept("wr_accept", exp_wait);
    chk("wr_c0_dreq", 64'(wr_burst_data_req), 0);
    for (int c = 1; c <= fin; c++) begin
      nxt();
      if (c == 2) begin
        wr_burst_len = 10'($urandom);
        if ($urandom_range(0, 1) == 1) wr_burst_req = 1'b0;
      end
      if (prev) begin
        b = beat_val(mode, k);
        wr_burst_data = b;
        mdl[idx_of(a, k)]   = b;
        known[idx_of(a, k)] = 1'b1;
        k++;
      end else begin
        wr_burst_data = rnd64();
      end
      prev = wr_burst_data_req;
      chk("wr_dreq", 64'(wr_burst_data_req), 64'(c <= n));
      chk("wr_fin", 64'(wr_burst_finish), 64'(c == fin));
      chk("wr_busy", 64'(busy), 1);
      chk("wr_no_rdv", 64'(rd_burst_data_valid), 0);
    end
    wr_burst_req = 1'b0;
  endtask

  task automatic do_rd(input logic [31:0] a, input int n,
                       input int exp_wait);
    int fin = (n == 0) ? 1 : n + RD_FIN_OFS;
    int li;
    bit v;
    rd_burst_req  = 1'b1;
    rd_burst_len  = 10'(n);
    rd_burst_addr = a;
    wait_accept("rd_accept", exp_wait);
    chk("rd_c0_v", 64'(rd_burst_data_valid), 0);
    for (int c = 1; c <= fin; c++) begin
      nxt();
      if (c == 2) begin
        rd_burst_len = 10'($urandom);
        if ($urandom_range(0, 1) == 1) rd_burst_req = 1'b0;
      end
      v = (n > 0) && (c >= 2) && (c <= n + 1);
      chk("rd_valid", 64'(rd_burst_data_valid), 64'(v));
      chk("rd_fin", 64'(rd_burst_finish), 64'(c == fin));
      chk("rd_busy", 64'(busy), 1);
      chk("rd_no_dreq", 64'(wr_burst_data_req), 0);
      if (v && known[idx_of(a, c - 2)])
        chk("rd_data", rd_burst_data, mdl[idx_of(a, c - 2)]);
      if (c == fin && n > 0) begin
        li = idx_of(a, n - 1);
        if (known[li]) chk("rd_hold", rd_burst_data, mdl[li]);
      end
    end
    rd_burst_req = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_dreq"}, 64'(wr_burst_data_req), 0);
    chk({tag, "_wfin"}, 64'(wr_burst_finish), 0);
    chk({tag, "_rdv"}, 64'(rd_burst_data_valid), 0);
    chk({tag, "_rdat"}, rd_burst_data, 0);
    chk({tag, "_rfin"}, 64'(rd_burst_finish), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
  endtask

  initial begin
    logic [31:0] a;
    int n;
    rst = 1'b1;
    wr_burst_req = 1'b0;
    wr_burst_len = '0;
    wr_burst_addr = '0;
    wr_burst_data = '0;
    rd_burst_req = 1'b0;
    rd_burst_len = '0;
    rd_burst_addr = '0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    @(negedge mem_clk);
    chk_quiet("rst");
    nxt();
    nxt();
    rst = 1'b0;
    nxt();
    chk_quiet("post_rst");

    // Basic write then read, byte-replicated beats 01..04.
    do_wr(32'h100, 4, 2, 0);
    do_rd(32'h100, 4, 1);

    // DDR tester pattern, back-to-back write/read pairs.
    for (int i = 0; i < 8; i++) begin
      do_wr(32'h0200_0000 + 32'(i * 128), 128, 1, 1);
      do_rd(32'h0200_0000 + 32'(i * 128), 128, 1);
    end

    // Wrap at the top of the RAM.
    do_wr(32'd1020, 8, 0, 1);
    do_rd(32'd1020, 8, 1);
    do_rd(32'd0, 4, 1);

    // Simultaneous requests: write wins, read follows.
    rd_burst_req  = 1'b1;
    rd_burst_len  = 10'd6;
    rd_burst_addr = 32'h250;
    do_wr(32'h250, 6, 0, 1);
    do_rd(32'h250, 6, 1);

    // Zero-length bursts leave RAM untouched.
    do_wr(32'h250, 0, 0, 1);
    do_rd(32'h250, 0, 1);
    do_rd(32'h250, 6, 1);

    // Reset in cycle 3 of a 16-beat write.
    do_wr(32'h300, 16, 0, 1);
    nxt();
    wr_burst_req  = 1'b1;
    wr_burst_len  = 10'd16;
    wr_burst_addr = 32'h300;
    chk("rst_acc_busy", 64'(busy), 0);
    nxt();
    wr_burst_data = rnd64();
    nxt();
    wr_burst_data = 64'hDEAD_BEEF_0BAD_F00D;
    mdl[idx_of(32'h300, 0)] = wr_burst_data;
    nxt();
    wr_burst_data = rnd64();
    rst = 1'b1;
    #1;
    chk_quiet("midrst");
    wr_burst_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk_quiet("rsthold");
    end
    rst = 1'b0;
    nxt();
    chk_quiet("rst_idle");
    do_wr(32'h340, 2, 0, 0);
    do_rd(32'h300, 16, 1);
    do_rd(32'h340, 2, 1);

    // Random back-to-back bursts.
    for (int i = 0; i < 40; i++) begin
      a = $urandom();
      n = $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 1) do_wr(a, n, 0, 1);
      else do_rd(a, n, 1);
    end

    nxt();
    nxt();
    chk("end_busy", 64'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
